cmd_dispatcher: RTL and testbench

Parametrised opcode-to-command dispatcher between the host packet parser and the GPU engines (swap, clean, vertex load, edge load, status, ...).
- Each accepted opcode becomes a one-cycle CMD strobe to one engine channel.
- A command for a busy engine is held in a per-channel pending slot until the engine frees or a timeout expires. It is not silently dropped.
- Reports accept/reject/timeout events back to the host side.

---
 rtl/cmd_dispatcher.sv | 126 ++++++++++++
 tb/tb_cmd_dispatcher.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// Opcode-to-command dispatcher: one start strobe per engine channel, with a pending slot per busy channel.
// Optional statistics counters are built when CMD_DISPATCH_STATS_EN is defined.
module cmd_dispatcher #(
   parameter int          NUM_CH       = 8,
   parameter int          OPCODE_W     = 8,
   parameter int          OP_BASE      = 1,
   parameter logic [31:0] BYPASS_MASK  = 32'h0000_0001,
   parameter int          PEND_TIMEOUT = 255
) (
   input  logic                CLK,
   input  logic                rst,
   input  logic                packet_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [NUM_CH-1:0]   BUSY,
   output logic [NUM_CH-1:0]   CMD,
   output logic [NUM_CH-1:0]   pending,
   output logic                ack,
   output logic                err_unknown,
   output logic                err_dup,
   output logic [NUM_CH-1:0]   err_timeout,
   output logic [15:0]         stat_issued,
   output logic [15:0]         stat_dropped
);

   localparam int TW = $clog2(PEND_TIMEOUT + 1);
   localparam logic [TW-1:0]     T_LAST = TW'(PEND_TIMEOUT - 1);
   localparam logic [OPCODE_W:0] BASE_X = (OPCODE_W + 1)'(OP_BASE);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   logic [NUM_CH-1:0] state_q, state_d;
   logic [TW-1:0]     timer_q [NUM_CH];
   logic [TW-1:0]     timer_d [NUM_CH];
   logic [NUM_CH-1:0] sel, cmd_d, tmo_d;
   logic [OPCODE_W:0] op_ext, idx;
   logic              valid, ack_d, dup_d, unk_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      op_ext  = {1'b0, opcode};
      idx     = op_ext - BASE_X;
      valid   = (op_ext >= BASE_X) && (32'(idx) < NUM_CH);
      unk_d   = packet_ready && !valid;
      state_d = state_q;
      cmd_d   = '0;
      tmo_d   = '0;
      ack_d   = 1'b0;
      dup_d   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         timer_d[i] = timer_q[i];
         sel[i]     = packet_ready && valid && (32'(idx) == i);
      end

      for (int i = 0; i < NUM_CH; i++) begin
         if (state_q[i] == ST_IDLE) begin
            if (sel[i]) begin
               ack_d = 1'b1;
               if (BYPASS_MASK[i] || !BUSY[i]) begin
                  cmd_d[i] = 1'b1;
               end else begin
                  state_d[i] = ST_PEND;
                  timer_d[i] = '0;
               end
            end
         end else begin
            // A packet for an occupied slot is discarded; the slot still resolves this cycle.
            if (sel[i]) dup_d = 1'b1;
            if (!BUSY[i]) begin
               cmd_d[i]   = 1'b1;
               state_d[i] = ST_IDLE;
            end else if (timer_q[i] == T_LAST) begin
               tmo_d[i]   = 1'b1;
               state_d[i] = ST_IDLE;
            end else begin
               timer_d[i] = timer_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q     <= '0;
         CMD         <= '0;
         ack         <= 1'b0;
         err_unknown <= 1'b0;
         err_dup     <= 1'b0;
         err_timeout <= '0;
         // NOTE: timers are few flops, not a RAM, so resetting them is cheap and keeps state deterministic.
         for (int i = 0; i < NUM_CH; i++) timer_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         CMD         <= cmd_d;
         ack         <= ack_d;
         err_unknown <= unk_d;
         err_dup     <= dup_d;
         err_timeout <= tmo_d;
         for (int i = 0; i < NUM_CH; i++) timer_q[i] <= timer_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) pending[i] = (state_q[i] == ST_PEND);
   end

`ifdef CMD_DISPATCH_STATS_EN
   // Counters advance on the same edge as the strobes they count, and saturate.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         stat_issued  <= '0;
         stat_dropped <= '0;
      end else begin
         if ((|cmd_d) && (stat_issued != 16'hFFFF))
            stat_issued <= stat_issued + 16'd1;
         if ((unk_d || dup_d || (|tmo_d)) && (stat_dropped != 16'hFFFF))
            stat_dropped <= stat_dropped + 16'd1;
      end
   end
`else
   assign stat_issued  = 16'h0000;
   assign stat_dropped = 16'h0000;
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed self-checking bench for cmd_dispatcher: default instance plus a PEND_TIMEOUT=4 instance.
module tb_cmd_dispatcher;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       packet_ready = 1'b0;
   logic [7:0] opcode = '0;
   logic [7:0] BUSY = '0;

   logic [7:0]  CMD, pending, err_timeout;
   logic        ack, err_unknown, err_dup;
   logic [15:0] stat_issued, stat_dropped;

   logic [7:0]  t_cmd, t_pending, t_err_timeout;
   logic        t_ack, t_err_unknown, t_err_dup;
   logic [15:0] t_stat_issued, t_stat_dropped;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   cmd_dispatcher dut (
      .CLK(CLK), .rst(rst), .packet_ready(packet_ready), .opcode(opcode), .BUSY(BUSY),
      .CMD(CMD), .pending(pending), .ack(ack), .err_unknown(err_unknown), .err_dup(err_dup),
      .err_timeout(err_timeout), .stat_issued(stat_issued), .stat_dropped(stat_dropped)
   );

   cmd_dispatcher #(.PEND_TIMEOUT(4)) dut_t (
      .CLK(CLK), .rst(rst), .packet_ready(packet_ready), .opcode(opcode), .BUSY(BUSY),
      .CMD(t_cmd), .pending(t_pending), .ack(t_ack), .err_unknown(t_err_unknown),
      .err_dup(t_err_dup), .err_timeout(t_err_timeout), .stat_issued(t_stat_issued),
      .stat_dropped(t_stat_dropped)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] op);
      opcode       = op;
      packet_ready = 1'b1;
      tick();
      packet_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_cmd", CMD, 0);
      check("rst_pending", pending, 0);
      check("rst_flags", {ack, err_unknown, err_dup}, 0);
      check("rst_tmo", err_timeout, 0);
      check("rst_stats", {stat_issued, stat_dropped}, 0);
      @(negedge CLK);
      rst = 1'b0;
      tick();

      // Plain issue on channel 2
      send(8'h03);
      check("issue_cmd", CMD, 8'b0000_0100);
      check("issue_ack", ack, 1);
      tick();
      check("issue_cmd_once", CMD, 0);
      check("issue_ack_once", ack, 0);

      // Bypass channel ignores BUSY
      BUSY = 8'h01;
      send(8'h01);
      check("bypass_cmd", CMD, 8'h01);
      check("bypass_pend", pending, 0);
      check("bypass_ack", ack, 1);
      BUSY = 8'h00;
      tick();

      // Channel 1 queued while busy, released after 10 cycles
      BUSY = 8'h02;
      send(8'h02);
      check("q_pend", pending, 8'h02);
      check("q_ack", ack, 1);
      check("q_cmd", CMD, 0);
      for (int k = 0; k < 9; k++) begin
         tick();
         check("q_wait_cmd", CMD, 0);
         check("q_wait_pend", pending, 8'h02);
      end
      BUSY = 8'h00;
      tick();
      check("rel_cmd", CMD, 8'h02);
      check("rel_pend", pending, 0);
      tick();
      check("rel_cmd_once", CMD, 0);

      // Duplicate and unknown opcodes
      BUSY = 8'h04;
      send(8'h03);
      check("p2_pend", pending, 8'h04);
      send(8'h03);
      check("dup_flag", err_dup, 1);
      check("dup_noack", ack, 0);
      check("dup_pend", pending, 8'h04);
      send(8'h00);
      check("unk_00", {err_unknown, ack, err_dup}, 3'b100);
      send(8'h09);
      check("unk_09", {err_unknown, ack, err_dup}, 3'b100);
      send(8'h08);
      check("top_ch_cmd", CMD, 8'h80);
      check("top_ch_flags", {err_unknown, ack}, 2'b01);

      // Duplicate in the very cycle the pending slot releases
      BUSY = 8'h00;
      send(8'h03);
      check("duprel_dup", err_dup, 1);
      check("duprel_cmd", CMD, 8'h04);
      check("duprel_pend", pending, 0);
      check("duprel_ack", ack, 0);
      tick();
`ifdef CMD_DISPATCH_STATS_EN
      check("stat_issued", stat_issued, 5);
      check("stat_dropped", stat_dropped, 4);
`else
      check("stat_issued_tied", stat_issued, 0);
      check("stat_dropped_tied", stat_dropped, 0);
`endif

      // Timeout after 4 busy cycles (PEND_TIMEOUT=4 instance)
      BUSY = 8'h10;
      send(8'h05);
      check("to_pend", t_pending, 8'h10);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("to_tmo", t_err_timeout, (k == 4) ? 8'h10 : 8'h00);
         check("to_pend_k", t_pending, (k < 4) ? 8'h10 : 8'h00);
         check("to_nocmd", t_cmd, 0);
      end
      tick();
      check("to_tmo_once", t_err_timeout, 0);
      BUSY = 8'h00;
      tick();
      check("to_dropped", t_cmd, 0);
      check("to_default_cmd", CMD, 8'h10);

      // Asynchronous reset while channel 1 is pending
      BUSY = 8'h02;
      send(8'h02);
      check("ar_pend", pending, 8'h02);
      #3;
      rst = 1'b1;
      #1;
      check("ar_pend_clr", pending, 0);
      check("ar_flags_clr", {ack, err_unknown, err_dup}, 0);
      check("ar_cmd_clr", CMD, 0);
      check("ar_stats_clr", {stat_issued, stat_dropped}, 0);
      #3;
      rst  = 1'b0;
      BUSY = 8'h00;
      tick();
      check("ar_no_cmd", CMD, 0);
      check("ar_no_tmo", err_timeout, 0);
      tick();
      check("ar_no_cmd2", CMD, 0);
      check("ar_pend_idle", pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
